// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Handshake, operand and HI/LO bundle between the decode/register-file
//   stage (master) and the iterative multiply/divide unit (slave).
//   start, op        : launch request and operation select (MULT/MULTU/DIV/DIVU)
//   rs_data, rt_data : operands from register file Read Data 1 / Read Data 2
//   hi_we, lo_we     : MTHI / MTLO write strobes (data taken from rs_data)
//   busy, done       : operation in progress / one-cycle result-ready pulse
//   hi, lo           : architectural HI/LO registers
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative MIPS multiply/divide unit with HI/LO registers. Shift-add
//   multiply and restoring divide on operand magnitudes, one bit per cycle,
//   with sign correction applied in a single fix-up cycle.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : mul_div_unit_if slave (start/op/operands/MTHI/MTLO in,
//          busy/done/hi/lo out)
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO accepted
//   CALC  | 32 iterations, one product/quotient bit per cycle
//   FIX   | sign correction, HI/LO written
//   DONE  | result valid for one cycle; new start or MTHI/MTLO accepted
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rstn,
  mul_div_unit_if.slave bus
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic         div_q;
  logic         neg_res;
  logic         neg_rem;
  logic         div0;
  logic [W-1:0] mcand;
  logic [W-1:0] acc_hi;
  logic [W-1:0] acc_lo;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

  logic           idle_like;
  logic [W-1:0]   rs_mag;
  logic [W-1:0]   rt_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     div_tr;
  logic [W:0]     div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    // op[0]=0 selects the signed variants
    rs_mag    = (!bus.op[0] && bus.rs_data[W-1]) ? -bus.rs_data : bus.rs_data;
    rt_mag    = (!bus.op[0] && bus.rt_data[W-1]) ? -bus.rt_data : bus.rt_data;
    // multiply: acc_hi:acc_lo holds partial product : remaining multiplier bits
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    // divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
    div_tr    = {acc_hi, acc_lo[W-1]};
    div_diff  = div_tr - {1'b0, mcand};
    prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    // divide by zero yields all-ones quotient; the remainder path already
    // reproduces the original dividend after sign correction
    q_fix     = div0 ? '1 : (neg_res ? -acc_lo : acc_lo);
    r_fix     = neg_rem ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (idle_like) begin
        if (bus.hi_we) hi_q <= bus.rs_data;
        if (bus.lo_we) lo_q <= bus.rs_data;
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= CALC;
            cnt     <= '0;
            div_q   <= bus.op[1];
            neg_res <= !bus.op[0] && (bus.rs_data[W-1] ^ bus.rt_data[W-1]);
            neg_rem <= !bus.op[0] && bus.rs_data[W-1];
            div0    <= bus.op[1] && (bus.rt_data == '0);
            mcand   <= bus.op[1] ? rt_mag : rs_mag;
            acc_hi  <= '0;
            acc_lo  <= bus.op[1] ? rs_mag : rt_mag;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (div_q) begin
            if (!div_diff[W]) begin
              acc_hi <= div_diff[W-1:0];
              acc_lo <= {acc_lo[W-2:0], 1'b1};
            end else begin
              acc_hi <= div_tr[W-1:0];
              acc_lo <= {acc_lo[W-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (div_q) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            hi_q <= prod_fix[2*W-1:W];
            lo_q <= prod_fix[W-1:0];
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == CALC) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed vectors for mul_div_unit: latency/handshake, signed and unsigned
//   multiply/divide, divide-by-zero, signed overflow, MTHI/MTLO, ignored
//   requests while busy, asynchronous reset mid-operation and back-to-back ops.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int bcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lat++;
    if (bus.busy) bcnt++;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit hold);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
  endtask

  task automatic wait_done();
    while (!bus.done && lat < 100) step();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi",   bus.hi,   0);
    chk("rst_lo",   bus.lo,   0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rstn = 1'b1;

    // MULTU max x max, latency and busy length
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    chk("multu_lat",  lat,  33);
    chk("multu_busy", bcnt, 33);
    chk("multu_hi",   bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo",   bus.lo, 32'h0000_0001);
    step();
    chk("done_pulse", bus.done, 0);

    // MULT -7 * 6 = -42
    start_op(OP_MULT, 32'hFFFF_FFF9, 32'd6, 1'b0);
    wait_done();
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFD6);

    // DIV -7 / 2 = -3 rem -1
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done();
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    // DIVU 100 / 0
    start_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
    wait_done();
    chk("div0_lat", lat, 33);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'd100);

    // DIV signed overflow
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0000_0000);

    // MTHI while idle
    @(negedge clk);
    bus.hi_we   = 1'b1;
    bus.rs_data = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    chk("mthi", bus.hi, 32'h0000_1234);

    // MTLO/start while busy ignored, operand change ignored
    start_op(OP_MULTU, 32'd3, 32'd5, 1'b0);
    repeat (4) step();
    bus.lo_we   = 1'b1;
    bus.start   = 1'b1;
    bus.op      = OP_DIVU;
    bus.rs_data = 32'h0000_DEAD;
    bus.rt_data = 32'd7;
    step();
    bus.lo_we = 1'b0;
    bus.start = 1'b0;
    chk("busy_mtlo_lo", bus.lo, 32'h8000_0000);
    chk("busy_hold_hi", bus.hi, 32'h0000_1234);
    bus.rs_data = 32'h5555_5555;
    wait_done();
    chk("busy_ign_lat", lat, 33);
    chk("busy_ign_lo",  bus.lo, 32'd15);
    chk("busy_ign_hi",  bus.hi, 32'd0);

    // asynchronous reset in the middle of DIVU 50/3
    start_op(OP_DIVU, 32'd50, 32'd3, 1'b0);
    repeat (10) step();
    chk("pre_rst_busy", bus.busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_lo",   bus.lo,   0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("arst_idle_busy", bus.busy, 0);
    start_op(OP_DIVU, 32'd50, 32'd3, 1'b0);
    wait_done();
    chk("divu_lo", bus.lo, 32'd16);
    chk("divu_hi", bus.hi, 32'd2);

    // back-to-back with start held through DONE
    start_op(OP_MULTU, 32'd3, 32'd5, 1'b1);
    bus.op      = OP_DIVU;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd4;
    wait_done();
    chk("b2b1_lat", lat, 33);
    chk("b2b1_lo",  bus.lo, 32'd15);
    lat = 0;
    step();
    bus.start = 1'b0;
    chk("b2b_restart_busy", bus.busy, 1);
    wait_done();
    chk("b2b2_lat", lat, 34);
    chk("b2b2_lo",  bus.lo, 32'd2);
    chk("b2b2_hi",  bus.hi, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file and takes its two operands from Read Data 1 (rs) and Read Data 2 (rt). It executes MULT, MULTU, DIV and DIVU over 34 cycles, with a start/busy/done handshake, and holds the result in HI/LO for MFHI/MFLO. It also accepts direct HI/LO writes for MTHI/MTLO.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported; it matches the register width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: launch the operation in `op`. Sampled only while `busy`=0.
- `op` input 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` input 32: multiplicand or dividend, from register file Read Data 1.
- `rt_data` input 32: multiplier or divisor, from register file Read Data 2.
- `hi_we` input 1: MTHI; write `rs_data` into HI.
- `lo_we` input 1: MTLO; write `rs_data` into LO.
- `busy` output 1: operation in progress; the upstream stage must stall MFHI/MFLO/MTHI/MTLO and new starts.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States:
  - IDLE
  - CALC: 32 iterations, 5-bit counter
  - FIX: sign correction and HI/LO write
  - DONE: one cycle
- Transitions:
  - IDLE or DONE with `start`=1 → CALC. On the same edge, latch `op`, take operand magnitudes (signed ops only), record result signs, clear the counter.
  - DONE with `start`=0 → IDLE.
  - CALC → FIX when the counter reaches 31.
  - FIX → DONE.
- Multiply: shift-add, one bit per CALC cycle, producing a 64-bit unsigned product of the magnitudes.
  - In FIX, negate the product if the signed op has operands of differing signs.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per CALC cycle, on magnitudes.
  - In FIX, negate the quotient if the signed op has operands of differing signs.
  - In FIX, negate the remainder if the signed op has a negative dividend. Quotient truncates toward zero.
  - LO = quotient, HI = remainder.
- Divide by zero (`rt_data`=0, DIV or DIVU): normal latency; result LO = 32'hFFFFFFFF, HI = `rs_data` as latched.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): LO = 32'h80000000, HI = 0. No trap.
- `hi_we`/`lo_we`:
  - Take effect on the edge where they are asserted and `busy`=0.
  - Ignored while `busy`=1.
  - If asserted together with an accepted `start`, the write occurs; the later FIX result overwrites it.
- `start` while `busy`=1 is ignored; there is no queueing.
- Operands are latched at the start edge. Later changes to `rs_data`/`rt_data` have no effect.

## Timing
- Reset (`rstn`=0, asynchronous): state IDLE, counter 0, `hi`=0, `lo`=0, `busy`=0, `done`=0. An in-flight operation is discarded and HI/LO are not written.
- For `start` accepted at edge N:
  - `busy`=1 after edges N through N+32 (33 cycles: CALC ×32, FIX).
  - At edge N+33, HI/LO are written and `done`=1 for that cycle, with `busy`=0.
  - At edge N+34, back to IDLE unless `start` is asserted in DONE.
- Back-to-back: `start` held in the DONE cycle is accepted at edge N+34, giving 34 cycles per operation.
- `hi`/`lo` are direct register outputs. They are unchanged during CALC/FIX, so stale HI/LO are visible until edge N+33.
- `busy` and `done` are decoded from state registers, with no combinational path from inputs.

## Test plan
- MULTU with rs=32'hFFFFFFFF, rt=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001. `done` rises exactly 33 edges after the start edge, and `busy` is high for 33 cycles.
- MULT with rs=-7 (32'hFFFFFFF9), rt=6 → HI=32'hFFFFFFFF, LO=32'hFFFFFFD6. DIV with rs=-7, rt=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU 100/0 → LO=32'hFFFFFFFF, HI=100. DIV 32'h80000000 / 32'hFFFFFFFF → LO=32'h80000000, HI=0.
- MTHI rs=32'h1234 while idle → `hi`=32'h1234 next edge. `lo_we` and `start` pulsed while `busy` → `lo` and the running operation are unaffected; `rs_data` changed mid-operation → result unaffected.
- `rstn` pulsed low at CALC cycle 10 of DIVU 50/3 → outputs immediately zero and state IDLE. A subsequent DIVU 50/3 gives LO=16, HI=2.
- Back-to-back MULTU 3×5 then DIVU 9/4 with `start` held through DONE → the first `done` shows LO=15. The second `done` arrives 34 cycles later with LO=2, HI=1.
